// File: rtl/dmem_ahb_master.sv
// Single-outstanding data-memory port bridging a core load/store request
// channel onto an AHB-Lite master, with misalignment, error and timeout handling.
module dmem_ahb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        sync_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_ERR   = 3'd3;
  localparam logic [2:0] S_MISAL = 3'd4;

  // Counter only needs to reach TIMEOUT_CYCLES-1; the last wait cycle aborts.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic [31:0]   addr_q;
  logic [1:0]    size_q;
  logic          write_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] to_cnt;
  logic          misaligned;

  assign misaligned = (req_size == 2'd3) ||
                      ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

  assign req_ready = (state == S_IDLE);
  assign HBURST    = 3'b000;

  // NOTE: every output is given a default before the case so no path can infer a latch.
  always_comb begin
    HADDR  = 32'h0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'b000;
    HWDATA = 32'h0;
    case (state)
      S_ADDR: begin
        HADDR  = addr_q;
        HTRANS = 2'b10;
        HWRITE = write_q;
        HSIZE  = {1'b0, size_q};
      end
      S_DATA, S_ERR: HWDATA = wdata_q;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state     <= S_IDLE;
      addr_q    <= 32'h0;
      size_q    <= 2'd0;
      write_q   <= 1'b0;
      wdata_q   <= 32'h0;
      to_cnt    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            write_q <= req_write;
            wdata_q <= req_wdata;
            state   <= misaligned ? S_MISAL : S_ADDR;
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            state  <= S_DATA;
            to_cnt <= '0;
          end
        end
        S_DATA: begin
          if (HREADY) begin
            // HRESP with HREADY high is a protocol violation; report it as an error.
            state     <= S_IDLE;
            rsp_valid <= 1'b1;
            rsp_error <= HRESP;
            rsp_rdata <= (!write_q && !HRESP) ? HRDATA : 32'h0;
          end else if (HRESP) begin
            state <= S_ERR;
          end else if (to_cnt == TO_LAST) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_ERR: begin
          if (HREADY) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
          end
        end
        S_MISAL: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b1;
          rsp_error <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ahb_master.sv
// Directed bench for dmem_ahb_master: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares each rsp_valid pulse.
module tb_dmem_ahb_master;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;

  typedef struct {
    logic [31:0] rdata;
    logic        error;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  dmem_ahb_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .sync_reset(sync_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (prev_valid) check("rsp_back_to_back", 32'(prev_valid), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_error", 32'(rsp_error), 32'(e.error));
        check("rsp_cycle", cyc, e.cyc);
      end
    end
    prev_valid = rsp_valid;
  end

  // Cycle N+k (spec numbering) follows edge N+k-1; acc is cyc after edge N.
  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] d, input logic [31:0] exp_rd,
                       input logic exp_er, input int lat, output int acc);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_write = w; req_addr = a; req_size = s; req_wdata = d; req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    if (lat > 0) exp_q.push_back('{rdata: exp_rd, error: exp_er, cyc: acc + lat - 1});
    // Scramble request inputs: they must not reach the bus mid-transfer.
    req_valid = 1'b0;
    req_write = ~w; req_addr = ~a; req_size = ~s; req_wdata = ~d;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
    check({tag, "_haddr"}, HADDR, 32'd0);
    check({tag, "_htrans"}, 32'(HTRANS), 32'd0);
    check({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
    check({tag, "_hsize"}, 32'(HSIZE), 32'd0);
    check({tag, "_hburst"}, 32'(HBURST), 32'd0);
    check({tag, "_hwdata"}, HWDATA, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [1:0]  ms_size [5] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [31:0] ms_addr [5] = '{32'h3, 32'h0, 32'h2, 32'h2, 32'h3};
    logic        ms_bad  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset with a pending request: reset must win over acceptance.
    sync_reset = 1'b1; req_valid = 1'b1; req_write = 1'b0;
    req_addr = 32'h10; req_size = 2'd2; req_wdata = 32'h0;
    HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    sync_reset = 1'b0; req_valid = 1'b0;
    check_reset_outputs("reset");

    // Zero-wait word load.
    HRDATA = 32'hDEADBEEF;
    issue(1'b0, 32'h100, 2'd2, 32'h0, 32'hDEADBEEF, 1'b0, 3, acc);
    @(negedge clk);
    check("load_htrans", 32'(HTRANS), 32'h2);
    check("load_hsize", 32'(HSIZE), 32'h2);
    check("load_haddr", HADDR, 32'h100);
    check("load_hwrite", 32'(HWRITE), 32'h0);
    check("load_req_ready_busy", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("load_data_htrans", 32'(HTRANS), 32'h0);
    @(negedge clk);
    HRDATA = 32'h0;
    check("load_done_ready", 32'(req_ready), 32'h1);

    // Word store with two data-phase wait states.
    HRDATA = 32'hAAAA5555;
    issue(1'b1, 32'h4, 2'd2, 32'h12345678, 32'h0, 1'b0, 5, acc);
    @(negedge clk);
    check("store_hwrite", 32'(HWRITE), 32'h1);
    check("store_haddr", HADDR, 32'h4);
    check("store_addr_hwdata", HWDATA, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      HREADY = (i == 2);
      check("store_hwdata", HWDATA, 32'h12345678);
    end
    @(negedge clk);
    check("store_done_hwdata", HWDATA, 32'h0);

    // Alignment table: misaligned requests never reach the bus.
    HRDATA = 32'h11223344;
    for (int t = 0; t < 5; t++) begin
      issue(1'b0, ms_addr[t], ms_size[t], 32'h0,
            ms_bad[t] ? 32'h0 : 32'h11223344, ms_bad[t], ms_bad[t] ? 2 : 3, acc);
      @(negedge clk);
      check("align_htrans", 32'(HTRANS), ms_bad[t] ? 32'h0 : 32'h2);
      if (!ms_bad[t]) check("align_hsize", 32'(HSIZE), 32'(ms_size[t]));
      @(negedge clk);
      check("align_htrans2", 32'(HTRANS), 32'h0);
      if (!ms_bad[t]) @(negedge clk);
    end

    // Two-cycle ERROR response.
    issue(1'b0, 32'h20, 2'd2, 32'h0, 32'h0, 1'b1, 4, acc);
    @(negedge clk);
    @(negedge clk); HREADY = 1'b0; HRESP = 1'b1;
    @(negedge clk); HREADY = 1'b1; HRESP = 1'b1;
    check("err_htrans", 32'(HTRANS), 32'h0);
    @(negedge clk); HRESP = 1'b0;
    wait_cycles(2);

    // HRESP with HREADY high in the data phase.
    issue(1'b0, 32'h24, 2'd2, 32'h0, 32'h0, 1'b1, 3, acc);
    @(negedge clk);
    @(negedge clk); HRESP = 1'b1; HRDATA = 32'hCAFEF00D;
    @(negedge clk); HRESP = 1'b0;

    // Timeout: HREADY held low through the data phase.
    issue(1'b0, 32'h40, 2'd2, 32'h0, 32'h0, 1'b1, 18, acc);
    @(negedge clk);
    @(negedge clk); HREADY = 1'b0;
    wait_cycles(16);
    check("timeout_htrans", 32'(HTRANS), 32'h0);
    check("timeout_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("timeout_htrans_after", 32'(HTRANS), 32'h0);
    HREADY = 1'b1;

    // Reset during the data phase abandons the transfer.
    issue(1'b1, 32'h80, 2'd2, 32'h55AA55AA, 32'h0, 1'b0, 0, acc);
    @(negedge clk);
    @(negedge clk); HREADY = 1'b0; sync_reset = 1'b1;
    check("mid_reset_hwdata_before", HWDATA, 32'h55AA55AA);
    @(negedge clk); sync_reset = 1'b0; HREADY = 1'b1;
    check_reset_outputs("mid_reset");
    HRDATA = 32'h0BADF00D;
    issue(1'b0, 32'h84, 2'd2, 32'h0, 32'h0BADF00D, 1'b0, 3, acc);
    wait_cycles(4);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
